hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage datapath. Sits beside ID/EXE/MEM.
//  Compares ID source regs against EXE/MEM destinations and drives the EXE
//  operand-forwarding mux selects. Stalls IF/ID and injects a bubble on load-use.
//  Freezes the whole pipe while a data-memory load is outstanding, and keeps
//  stall/forward statistics plus a sticky memory-timeout flag.
// PARAMETERS
//  MAX_WAIT  16  max MEMWAIT cycles before timeout_err sets (>=1)
//  CNT_W     32  width of the saturating performance counters
// PORTS
//  clk          in   1      clock, all state on rising edge
//  clrn         in   1      reset; asynchronous, active-HIGH
//  id_valid     in   1      ID holds a real instruction
//  id_rs        in   5      ID source register a
//  id_rt        in   5      ID source register b
//  id_use_rs    in   1      instruction reads rs
//  id_use_rt    in   1      instruction reads rt
//  exe_wreg     in   1      EXE instr writes regfile
//  exe_m2reg    in   1      EXE instr is a load
//  exe_d        in   5      EXE destination reg
//  mem_wreg     in   1      MEM instr writes regfile
//  mem_m2reg    in   1      MEM instr is a load
//  mem_d        in   5      MEM destination reg
//  mem_ready    in   1      data memory returns load data this cycle
//  fwda         out  2      operand-a select: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM load data
//  fwdb         out  2      operand-b select, same encoding
//  wpcir        out  1      1 = PC and IF/ID registers update
//  bubble       out  1      1 = zero the control bits written into ID/EXE
//  freeze       out  1      1 = ID/EXE, EXE/MEM, MEM/WB registers hold
//  stall_cnt    out  CNT_W  count of load-use bubble cycles
//  wait_cnt     out  CNT_W  count of MEMWAIT cycles
//  fwd_cnt      out  CNT_W  count of cycles with any nonzero fwda/fwdb
//  timeout_err  out  1      sticky: MEMWAIT lasted MAX_WAIT cycles
// BEHAVIOUR
//  - Match rule: src==dst, dst!=0, and the stage's wreg=1. Register 0 is never forwarded.
//  - Forward per operand, only if id_use_x: EXE match with exe_m2reg=0 -> 01.
//    Otherwise MEM match -> 10 if mem_m2reg=0, 11 if mem_m2reg=1. Otherwise 00.
//    EXE takes priority over MEM.
//  - Load-use: id_valid and (id_use_rs or id_use_rt) matching an EXE dst with
//    exe_m2reg=1 -> wpcir=0, bubble=1, fwdx=00 for that cycle (Mealy, 0 latency).
//  - FSM states RUN, MEMWAIT.
//    RUN: if mem_m2reg & mem_wreg & !mem_ready -> MEMWAIT next cycle. In the
//    entering cycle, freeze=1 and wpcir=0 are already asserted (Mealy), bubble=0.
//  - MEMWAIT: freeze=1, wpcir=0, bubble=0; forwarding outputs stay as computed.
//    Exit to RUN on mem_ready=1, and that cycle is non-frozen. The wait counter
//    increments each MEMWAIT cycle. When it reaches MAX_WAIT, timeout_err<=1 and
//    the FSM stays in MEMWAIT.
//  - Priority: MEM wait overrides load-use. bubble=0 whenever freeze=1, and the
//    load-use is re-evaluated after the freeze ends.
//  - Counters increment once per qualifying cycle, saturate at all-ones, never wrap.
//    stall_cnt counts bubble=1 cycles. fwd_cnt is not incremented when freeze=1.
//  - Reset (async, any state): state=RUN, wait counter=0, all perf counters=0,
//    timeout_err=0. While clrn=1: wpcir=1, bubble=0, freeze=0, fwda=fwdb=00.
//    Reset mid-MEMWAIT aborts the wait with no error.
//  - timeout_err is cleared only by reset.
// STRUCTURE
//  - Shared package/include: FWD_REG/FWD_EXE/FWD_MEM/FWD_LD select codes,
//    ST_RUN/ST_MEMWAIT encodings.
//  - One sub-module, sat_counter (CNT_W, inc, clk, clrn -> q), instanced 3x.
//  - Match/forward logic is combinational. FSM and wait counter are in the top module.
// TESTING
//  1. EXE writes r5 (alu), ID add r6,r5,r5 -> fwda=fwdb=01, wpcir=1, fwd_cnt+1.
//  2. EXE writes r0, ID reads r0 -> fwda=00. EXE r3 alu and MEM r3 alu -> 01 (EXE wins).
//  3. EXE lw r7, ID reads rt=r7 -> one cycle wpcir=0, bubble=1. Next cycle MEM lw r7
//     with mem_ready=1 -> fwdb=11, stall_cnt=1.
//  4. MEM lw with mem_ready=0 for 3 cycles, then 1 -> freeze=1 for 3 cycles, wait_cnt=3,
//     RUN afterwards, timeout_err=0.
//  5. MAX_WAIT=4, mem_ready held 0 -> timeout_err=1 after 4 MEMWAIT cycles; it stays 1
//     after mem_ready=1.
//  6. Assert clrn mid-MEMWAIT -> freeze=0 and counters=0 immediately. Force counters near
//     all-ones -> they hold at max.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_fwd_ctrl_pkg
// Brief  : Forward-select codes, FSM encodings and match helpers shared by
//          the hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_fwd_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EXE = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_LD  = 2'b11;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MEMWAIT = 1'b1
   } state_t;

   // r0 is hardwired to zero, so it never produces a forwardable value.
   function automatic logic reg_match(input logic [4:0] src,
                                      input logic [4:0] dst,
                                      input logic       wreg);
      return wreg && (dst != 5'd0) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic       use_src,
                                          input logic [4:0] src,
                                          input logic       exe_wreg,
                                          input logic       exe_m2reg,
                                          input logic [4:0] exe_d,
                                          input logic       mem_wreg,
                                          input logic       mem_m2reg,
                                          input logic [4:0] mem_d);
      logic [1:0] sel;
      sel = FWD_REG;
      if (use_src) begin
         if (reg_match(src, exe_d, exe_wreg) && !exe_m2reg)
            sel = FWD_EXE;
         else if (reg_match(src, mem_d, mem_wreg))
            sel = mem_m2reg ? FWD_LD : FWD_MEM;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] r_q;

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn)
         r_q <= '0;
      else if (inc && (r_q != {CNT_W{1'b1}}))
         r_q <= r_q + 1'b1;
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_fwd_ctrl
// Brief  : Forwarding-select, load-use stall and memory-wait freeze control
//          for the 5-stage pipe, with saturating stall/wait/forward counters.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             exe_wreg,
   input  logic             exe_m2reg,
   input  logic [4:0]       exe_d,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [4:0]       mem_d,
   input  logic             mem_ready,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             wpcir,
   output logic             bubble,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [CNT_W-1:0] fwd_cnt,
   output logic             timeout_err
);

   localparam int                  c_WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WAIT_W-1:0] r_wait;
   logic                r_timeout;

   logic [1:0] w_fwda_raw;
   logic [1:0] w_fwdb_raw;
   logic [1:0] w_fwda;
   logic [1:0] w_fwdb;
   logic       w_load_use;
   logic       w_mem_miss;
   logic       w_freeze;
   logic       w_bubble;
   logic       w_wpcir;
   logic       w_fwd_any;

   assign w_fwda_raw = fwd_sel(id_use_rs, id_rs, exe_wreg, exe_m2reg, exe_d,
                               mem_wreg, mem_m2reg, mem_d);
   assign w_fwdb_raw = fwd_sel(id_use_rt, id_rt, exe_wreg, exe_m2reg, exe_d,
                               mem_wreg, mem_m2reg, mem_d);

   assign w_load_use = id_valid && exe_m2reg &&
                       ((id_use_rs && reg_match(id_rs, exe_d, exe_wreg)) ||
                        (id_use_rt && reg_match(id_rt, exe_d, exe_wreg)));

   assign w_mem_miss = mem_m2reg && mem_wreg && !mem_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_freeze    = 1'b0;
      w_bubble    = 1'b0;
      w_fwda      = w_fwda_raw;
      w_fwdb      = w_fwdb_raw;
      case (r_state)
         ST_RUN: begin
            if (w_mem_miss) begin
               w_state_nxt = ST_MEMWAIT;
               w_freeze    = 1'b1;
            end
         end
         ST_MEMWAIT: begin
            if (mem_ready)
               w_state_nxt = ST_RUN;
            else
               w_freeze = 1'b1;
         end
         default: w_state_nxt = ST_RUN;
      endcase
      // A freeze masks the load-use; it is seen again once the pipe moves.
      if (!w_freeze && w_load_use) begin
         w_bubble = 1'b1;
         w_fwda   = FWD_REG;
         w_fwdb   = FWD_REG;
      end
      if (clrn) begin
         w_state_nxt = ST_RUN;
         w_freeze    = 1'b0;
         w_bubble    = 1'b0;
         w_fwda      = FWD_REG;
         w_fwdb      = FWD_REG;
      end
      w_wpcir = !(w_freeze || w_bubble);
   end

   // r_wait holds the MEMWAIT cycles already spent in the current wait.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_state   <= ST_RUN;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_MEMWAIT) begin
            if (r_wait >= c_WAIT_LAST)
               r_timeout <= 1'b1;
            if (mem_ready)
               r_wait <= '0;
            else if (r_wait < c_WAIT_LAST)
               r_wait <= r_wait + 1'b1;
         end else begin
            r_wait <= '0;
         end
      end
   end

   assign w_fwd_any = ((w_fwda != FWD_REG) || (w_fwdb != FWD_REG)) && !w_freeze;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .clrn (clrn),
      .inc  (w_bubble),
      .q    (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk  (clk),
      .clrn (clrn),
      .inc  (r_state == ST_MEMWAIT),
      .q    (wait_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
      .clk  (clk),
      .clrn (clrn),
      .inc  (w_fwd_any),
      .q    (fwd_cnt)
   );

   assign fwda        = w_fwda;
   assign fwdb        = w_fwdb;
   assign wpcir       = w_wpcir;
   assign bubble      = w_bubble;
   assign freeze      = w_freeze;
   assign timeout_err = r_timeout;

endmodule
`default_nettype wire
